// File: rtl/sram_mem_controller.sv
// Memory-stage controller: turns a 32-bit LDR/STR at a byte address into two
// sequential 16-bit SRAM half-word accesses, stalling the pipeline via ready.
module sram_mem_controller #(
  parameter int unsigned REGISTER_LEN  = 32,
  parameter int unsigned ADDR_BASE     = 1024,
  parameter int unsigned SRAM_ADDR_W   = 18,
  parameter int unsigned SRAM_DATA_W   = 16,
  parameter int unsigned ACCESS_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    mem_r_en,
  input  logic                    mem_w_en,
  input  logic [REGISTER_LEN-1:0] address,
  input  logic [REGISTER_LEN-1:0] wdata,
  output logic [REGISTER_LEN-1:0] rdata,
  output logic                    ready,
  output logic [SRAM_ADDR_W-1:0]  sram_addr,
  output logic                    sram_we_n,
  output logic [SRAM_DATA_W-1:0]  sram_dq_wr,
  output logic                    sram_dq_oe,
  input  logic [SRAM_DATA_W-1:0]  sram_dq_rd
);

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned WORD_W = SRAM_ADDR_W - 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOW  = 2'd1,
    S_HIGH = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [CNT_W-1:0]        r_cnt;
  logic [CNT_W-1:0]        w_cnt_nxt;

  logic [WORD_W-1:0]       r_word;
  logic [REGISTER_LEN-1:0] r_wdata;
  logic                    r_is_write;
  logic [REGISTER_LEN-1:0] r_rdata;
  logic [SRAM_ADDR_W-1:0]  r_sram_addr;
  logic                    r_sram_we_n;
  logic [SRAM_DATA_W-1:0]  r_sram_dq_wr;
  logic                    r_sram_dq_oe;

  logic                    w_req;
  logic                    w_last;
  logic [REGISTER_LEN-1:0] w_diff;
  logic [WORD_W-1:0]       w_word_idx;
  logic                    w_unused;
  logic                    w_acc_write;
  logic [WORD_W-1:0]       w_acc_word;
  logic [REGISTER_LEN-1:0] w_acc_wdata;
  logic [SRAM_ADDR_W-1:0]  w_addr_nxt;
  logic                    w_we_n_nxt;
  logic [SRAM_DATA_W-1:0]  w_dq_nxt;
  logic                    w_oe_nxt;

  // Byte address to word index; subtraction wraps for addresses below the base.
  assign w_diff     = address - REGISTER_LEN'(ADDR_BASE);
  assign w_word_idx = w_diff[SRAM_ADDR_W:2];
  assign w_unused   = ^{w_diff[REGISTER_LEN-1:SRAM_ADDR_W+1], w_diff[1:0]};

  assign w_req  = mem_r_en | mem_w_en;
  assign w_last = (r_cnt == CNT_W'(ACCESS_CYCLES - 1));

  // In IDLE the access is being accepted this cycle, so use the live inputs.
  assign w_acc_write = (r_state == S_IDLE) ? mem_w_en   : r_is_write;
  assign w_acc_word  = (r_state == S_IDLE) ? w_word_idx : r_word;
  assign w_acc_wdata = (r_state == S_IDLE) ? wdata      : r_wdata;

  assign ready = ((r_state == S_IDLE) && !w_req) || (r_state == S_DONE);

  assign rdata      = r_rdata;
  assign sram_addr  = r_sram_addr;
  assign sram_we_n  = r_sram_we_n;
  assign sram_dq_wr = r_sram_dq_wr;
  assign sram_dq_oe = r_sram_dq_oe;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next state plus next SRAM bus values, registered so the bus is glitch-free.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_addr_nxt  = r_sram_addr;
    w_we_n_nxt  = 1'b1;
    w_dq_nxt    = r_sram_dq_wr;
    w_oe_nxt    = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          w_state_nxt = S_LOW;
          w_cnt_nxt   = '0;
        end
      end
      S_LOW: begin
        if (w_last) begin
          w_state_nxt = S_HIGH;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_HIGH: begin
        if (w_last) begin
          w_state_nxt = S_DONE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase

    if (w_state_nxt == S_LOW) begin
      w_addr_nxt = {w_acc_word, 1'b0};
      w_we_n_nxt = ~w_acc_write;
      w_oe_nxt   = w_acc_write;
      if (w_acc_write) begin
        w_dq_nxt = w_acc_wdata[SRAM_DATA_W-1:0];
      end
    end else if (w_state_nxt == S_HIGH) begin
      w_addr_nxt = {w_acc_word, 1'b1};
      w_we_n_nxt = ~w_acc_write;
      w_oe_nxt   = w_acc_write;
      if (w_acc_write) begin
        w_dq_nxt = w_acc_wdata[REGISTER_LEN-1:SRAM_DATA_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_word       <= '0;
      r_wdata      <= '0;
      r_is_write   <= 1'b0;
      r_rdata      <= '0;
      r_sram_addr  <= '0;
      r_sram_we_n  <= 1'b1;
      r_sram_dq_wr <= '0;
      r_sram_dq_oe <= 1'b0;
    end else begin
      r_sram_addr  <= w_addr_nxt;
      r_sram_we_n  <= w_we_n_nxt;
      r_sram_dq_wr <= w_dq_nxt;
      r_sram_dq_oe <= w_oe_nxt;
      if ((r_state == S_IDLE) && w_req) begin
        r_word     <= w_word_idx;
        r_wdata    <= wdata;
        r_is_write <= mem_w_en;
      end
      // Read data is captured on the final cycle of each half-word phase.
      if (!r_is_write && w_last) begin
        if (r_state == S_LOW) begin
          r_rdata[SRAM_DATA_W-1:0] <= sram_dq_rd;
        end else if (r_state == S_HIGH) begin
          r_rdata[REGISTER_LEN-1:SRAM_DATA_W] <= sram_dq_rd;
        end
      end
    end
  end

endmodule

// File: tb/tb_sram_mem_controller.sv
// Scoreboard bench for sram_mem_controller: expected bus cycles and load
// results are queued when an access is issued and checked as the DUT runs.
module tb_sram_mem_controller;

  localparam int N = 2;

  typedef struct packed {
    logic        we_n;
    logic        oe;
    logic [17:0] addr;
    logic [15:0] data;
  } bus_t;

  logic        clk;
  logic        rst_n;
  logic        mem_r_en;
  logic        mem_w_en;
  logic [31:0] address;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic [17:0] sram_addr;
  logic        sram_we_n;
  logic [15:0] sram_dq_wr;
  logic        sram_dq_oe;
  logic [15:0] sram_dq_rd;

  logic [15:0] mem    [0:1023];
  logic [15:0] shadow [0:1023];
  bus_t        exp_bus  [$];
  logic [31:0] exp_done [$];
  logic [31:0] model_rdata;
  logic        mon_en;
  logic        prev_rdy;
  bus_t        mon_e;
  logic [31:0] mon_r;
  int          n_vec;
  int          n_err;

  sram_mem_controller #(
    .REGISTER_LEN (32),
    .ADDR_BASE    (1024),
    .SRAM_ADDR_W  (18),
    .SRAM_DATA_W  (16),
    .ACCESS_CYCLES(N)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mem_r_en  (mem_r_en),
    .mem_w_en  (mem_w_en),
    .address   (address),
    .wdata     (wdata),
    .rdata     (rdata),
    .ready     (ready),
    .sram_addr (sram_addr),
    .sram_we_n (sram_we_n),
    .sram_dq_wr(sram_dq_wr),
    .sram_dq_oe(sram_dq_oe),
    .sram_dq_rd(sram_dq_rd)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Asynchronous-read SRAM, write on the clock edge while we_n is low.
  assign sram_dq_rd = mem[sram_addr[9:0]];
  always @(posedge clk) begin
    if (!sram_we_n) mem[sram_addr[9:0]] = sram_dq_wr;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [17:0] sram_base(input logic [31:0] a);
    logic [31:0] d;
    d = a - 32'd1024;
    return {d[18:2], 1'b0};
  endfunction

  task automatic preload(input int idx, input logic [15:0] v);
    mem[idx]    = v;
    shadow[idx] = v;
  endtask

  // Monitor: stall cycles are SRAM phase cycles; the first ready cycle after a stall is DONE.
  always @(posedge clk) begin
    #2;
    if (mon_en) begin
      if (!ready) begin
        if (exp_bus.size() == 0) begin
          chk("bus_unexpected", 32'(exp_bus.size()), 32'd1);
        end else begin
          mon_e = exp_bus.pop_front();
          chk("we_n", 32'(sram_we_n), 32'(mon_e.we_n));
          chk("dq_oe", 32'(sram_dq_oe), 32'(mon_e.oe));
          chk("sram_addr", 32'(sram_addr), 32'(mon_e.addr));
          if (!mon_e.we_n) chk("dq_wr", 32'(sram_dq_wr), 32'(mon_e.data));
        end
      end else if (!prev_rdy) begin
        if (exp_done.size() == 0) begin
          chk("done_unexpected", 32'(exp_done.size()), 32'd1);
        end else begin
          mon_r = exp_done.pop_front();
          chk("rdata", rdata, mon_r);
        end
      end
    end
    prev_rdy = ready;
  end

  task automatic do_access(input logic rd, input logic wr, input logic [31:0] a,
                           input logic [31:0] wd, input logic midchg);
    logic [17:0] base;
    bus_t        e;
    int          k;
    base = sram_base(a);
    for (int p = 0; p < 2; p++) begin
      for (int c = 0; c < N; c++) begin
        e.we_n = ~wr;
        e.oe   = wr;
        e.addr = base | 18'(p);
        e.data = (p == 1) ? wd[31:16] : wd[15:0];
        exp_bus.push_back(e);
      end
    end
    if (wr) begin
      shadow[base[9:0]]         = wd[15:0];
      shadow[base[9:0] | 10'd1] = wd[31:16];
    end else begin
      model_rdata = {shadow[base[9:0] | 10'd1], shadow[base[9:0]]};
    end
    exp_done.push_back(model_rdata);
    @(negedge clk);
    mem_r_en = rd;
    mem_w_en = wr;
    address  = a;
    wdata    = wd;
    #1 chk("ready_on_req", 32'(ready), 32'd0);
    k = 0;
    while (!ready && k < 40) begin
      @(negedge clk);
      k++;
      if (midchg && k == 2) begin
        address = 32'd2000;
        wdata   = ~wd;
      end
    end
    chk("latency", 32'(k), 32'(2 * N + 1));
    mem_r_en = 1'b0;
    mem_w_en = 1'b0;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    mon_en = 1'b0;
    prev_rdy = 1'b1;
    model_rdata = 32'h0;
    rst_n = 1'b0;
    mem_r_en = 1'b0;
    mem_w_en = 1'b0;
    address = 32'h0;
    wdata = 32'h0;
    for (int i = 0; i < 1024; i++) preload(i, 16'h0);

    // Reset and idle
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_we_n", 32'(sram_we_n), 32'd1);
    chk("rst_oe", 32'(sram_dq_oe), 32'd0);
    chk("rst_addr", 32'(sram_addr), 32'd0);
    chk("rst_dq_wr", 32'(sram_dq_wr), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    #1 chk("idle_ready", 32'(ready), 32'd1);
    mon_en = 1'b1;

    // Store, load back, simultaneous enables, latched inputs
    do_access(1'b0, 1'b1, 32'd1032, 32'hDEADBEEF, 1'b0);
    do_access(1'b1, 1'b0, 32'd1032, 32'h0, 1'b0);
    do_access(1'b1, 1'b1, 32'd1024, 32'h12345678, 1'b0);
    chk("both_en_rdata_kept", rdata, 32'hDEADBEEF);
    do_access(1'b1, 1'b0, 32'd1024, 32'h0, 1'b0);
    preload(2, 16'h1111);
    preload(3, 16'h2222);
    preload(488, 16'h9999);
    preload(489, 16'h8888);
    do_access(1'b1, 1'b0, 32'd1028, 32'h0, 1'b1);
    do_access(1'b0, 1'b1, 32'd1036, 32'hFEEDFACE, 1'b1);
    do_access(1'b1, 1'b0, 32'd1036, 32'h0, 1'b0);

    // Random mix, including misaligned byte addresses
    for (int i = 0; i < 12; i++) begin
      if ($urandom_range(0, 1) == 1)
        do_access(1'b1, 1'b0, 32'd1024 + 32'(4 * $urandom_range(0, 255)) + 32'($urandom_range(0, 3)),
                  32'($urandom), 1'b0);
      else
        do_access(1'($urandom_range(0, 1)), 1'b1,
                  32'd1024 + 32'(4 * $urandom_range(0, 255)) + 32'($urandom_range(0, 3)),
                  32'($urandom), 1'b0);
    end

    // Address below the base wraps to the top of the SRAM
    do_access(1'b0, 1'b1, 32'd1020, 32'hA5A55A5A, 1'b0);
    do_access(1'b1, 1'b0, 32'd1020, 32'h0, 1'b0);
    @(negedge clk);
    chk("bus_q_empty", 32'(exp_bus.size()), 32'd0);
    chk("done_q_empty", 32'(exp_done.size()), 32'd0);

    // Reset during the HIGH phase of a write
    mon_en = 1'b0;
    mem_w_en = 1'b1;
    address = 32'd1040;
    wdata = 32'hCAFEF00D;
    repeat (3) @(negedge clk);
    #1 chk("pre_rst_we_n", 32'(sram_we_n), 32'd0);
    rst_n = 1'b0;
    mem_w_en = 1'b0;
    @(negedge clk);
    #1;
    chk("midrst_we_n", 32'(sram_we_n), 32'd1);
    chk("midrst_oe", 32'(sram_dq_oe), 32'd0);
    chk("midrst_ready", 32'(ready), 32'd1);
    chk("midrst_rdata", rdata, 32'h0);
    chk("midrst_addr", 32'(sram_addr), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    #1 chk("post_rst_ready", 32'(ready), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
